// File: rtl/disp_scan_ctrl.sv
// Display controller: accepts an 8-bit value, converts it to BCD one bit per clock,
// and scans three multiplexed 7-segment digits with blanking and leading-zero suppression.
module disp_scan_ctrl #(
    parameter int SCAN_DIV    = 32768,
    parameter int BLANK_CYC   = 64,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] value_in,
    input  logic       value_valid,
    output logic       value_ready,
    output logic       busy,
    output logic [6:0] segments,
    output logic [3:0] cathode
);

    localparam int            PW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] SCAN_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_P   = PW'(BLANK_CYC);
    localparam bit            LZ_EN     = (LZ_SUPPRESS != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_COMMIT
    } state_t;

    typedef enum logic [1:0] {
        SLOT_ONES,
        SLOT_TENS,
        SLOT_HUNDREDS
    } slot_t;

    state_t        state, state_next;
    logic          alive;
    logic [19:0]   shreg;
    logic [2:0]    bit_cnt;
    logic [11:0]   disp;
    logic          accept;

    logic [PW-1:0] prescaler;
    slot_t         slot, slot_next;
    logic          wrap;
    logic          load;
    logic          in_blank;
    logic [3:0]    digit_next;
    logic          sup_next;
    logic [6:0]    seg_next;
    logic [6:0]    seg_q;
    logic          suppress_q;

    // One double-dabble iteration: correct every nibble >= 5, then shift left.
    function automatic logic [19:0] dabble_step(input logic [19:0] r);
        logic [19:0] a;
        a = r;
        for (int i = 0; i < 3; i++) begin
            if (a[8+4*i +: 4] >= 4'd5)
                a[8+4*i +: 4] = a[8+4*i +: 4] + 4'd3;
        end
        return {a[18:0], 1'b0};
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h7E;
            4'd1:    s = 7'h30;
            4'd2:    s = 7'h6D;
            4'd3:    s = 7'h79;
            4'd4:    s = 7'h33;
            4'd5:    s = 7'h5B;
            4'd6:    s = 7'h5F;
            4'd7:    s = 7'h70;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h7B;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // alive holds ready low until the first edge after reset release.
    assign value_ready = alive && (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign accept      = value_valid && value_ready;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    // NOTE: default assigned first so no path through this block can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (accept) state_next = S_SHIFT;
            S_SHIFT:  if (bit_cnt == 3'd7) state_next = S_COMMIT;
            S_COMMIT: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alive   <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
            disp    <= '0;
        end else begin
            alive <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        shreg   <= {12'b0, value_in};
                        bit_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    shreg   <= dabble_step(shreg);
                    bit_cnt <= bit_cnt + 3'd1;
                end
                S_COMMIT: disp <= shreg[19:8];
                default: ;
            endcase
        end
    end

    assign wrap = (prescaler == SCAN_LAST);
    // The first edge after reset also loads the slot so the ones digit shows at once.
    assign load = wrap || !alive;

    always_comb begin
        slot_next = slot;
        if (wrap) begin
            case (slot)
                SLOT_ONES:     slot_next = SLOT_TENS;
                SLOT_TENS:     slot_next = SLOT_HUNDREDS;
                default:       slot_next = SLOT_ONES;
            endcase
        end
    end

    always_comb begin
        digit_next = disp[3:0];
        sup_next   = 1'b0;
        case (slot_next)
            SLOT_TENS: begin
                digit_next = disp[7:4];
                sup_next   = LZ_EN && (disp[11:8] == 4'd0) && (disp[7:4] == 4'd0);
            end
            SLOT_HUNDREDS: begin
                digit_next = disp[11:8];
                sup_next   = LZ_EN && (disp[11:8] == 4'd0);
            end
            default: ;
        endcase
        seg_next = sup_next ? 7'h00 : decode(digit_next);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler  <= '0;
            slot       <= SLOT_ONES;
            seg_q      <= '0;
            suppress_q <= 1'b0;
        end else begin
            prescaler <= wrap ? '0 : prescaler + PW'(1);
            slot      <= slot_next;
            if (load) begin
                seg_q      <= seg_next;
                suppress_q <= sup_next;
            end
        end
    end

    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = (prescaler < BLANK_P);
        end
    endgenerate

    assign segments = seg_q;

    always_comb begin
        cathode = 4'b1111;
        if (alive && !in_blank && !suppress_q) begin
            case (slot)
                SLOT_ONES:     cathode = 4'b1110;
                SLOT_TENS:     cathode = 4'b1101;
                SLOT_HUNDREDS: cathode = 4'b1011;
                default:       cathode = 4'b1111;
            endcase
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl: one instance with leading-zero suppression,
// one without, both with an 8-cycle slot and a 2-cycle blank window.
module tb_disp_scan_ctrl;

    typedef struct {
        logic [7:0] value;
        logic [6:0] h;
        logic [6:0] t;
        logic [6:0] o;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] vin0, vin1;
    logic       vv0, vv1;
    logic       vr0, vr1, busy0, busy1;
    logic [6:0] seg0, seg1;
    logic [3:0] cath0, cath1;

    int checks = 0;
    int errors = 0;
    int n;

    disp_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYC(2), .LZ_SUPPRESS(1)) dut0 (
        .clk(clk), .reset(rst_n), .value_in(vin0), .value_valid(vv0),
        .value_ready(vr0), .busy(busy0), .segments(seg0), .cathode(cath0)
    );

    disp_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYC(2), .LZ_SUPPRESS(0)) dut1 (
        .clk(clk), .reset(rst_n), .value_in(vin1), .value_valid(vv1),
        .value_ready(vr1), .busy(busy1), .segments(seg1), .cathode(cath1)
    );

    always #5 clk = ~clk;

    // Edges since reset release: slot position is n % 8, slot index (n / 8) % 3.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? vr0 : vr1;
    endfunction

    function automatic logic bsy(input int d);
        return (d == 0) ? busy0 : busy1;
    endfunction

    task automatic drive(input int d, input logic [7:0] v, input logic valid);
        if (d == 0) begin vin0 = v; vv0 = valid; end
        else        begin vin1 = v; vv1 = valid; end
    endtask

    // Send one value and check the busy/ready profile through the commit.
    task automatic send(input int d, input logic [7:0] v);
        int t;
        @(negedge clk);
        drive(d, v, 1'b1);
        for (t = 0; t < 50 && !rdy(d); t++) @(negedge clk);
        if (!rdy(d)) begin
            check("accept_timeout", 8'(rdy(d)), 8'd1);
            drive(d, v, 1'b0);
            return;
        end
        @(posedge clk);
        #1 drive(d, v, 1'b0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check($sformatf("busy_k%0d", i), 8'(bsy(d)), 8'd1);
            check($sformatf("ready_k%0d", i), 8'(rdy(d)), 8'd0);
        end
        @(negedge clk);
        check("busy_done", 8'(bsy(d)), 8'd0);
        check("ready_done", 8'(rdy(d)), 8'd1);
    endtask

    // Observe three full slots starting at the first slot boundary after now.
    // An expected segment value of 0 means the digit is suppressed.
    task automatic scan_check(input int d, input string name,
                              input logic [6:0] h, input logic [6:0] t, input logic [6:0] o);
        int g;
        int p, s;
        logic [6:0] e;
        logic [3:0] code, expc, c;
        logic [6:0] sg;
        @(negedge clk);
        for (g = 0; g < 50 && (n % 8) != 0; g++) @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            if (i > 0) @(negedge clk);
            p = n % 8;
            s = (n / 8) % 3;
            e    = (s == 0) ? o : (s == 1) ? t : h;
            code = (s == 0) ? 4'b1110 : (s == 1) ? 4'b1101 : 4'b1011;
            expc = (p < 2 || e == 7'h00) ? 4'b1111 : code;
            sg   = (d == 0) ? seg0 : seg1;
            c    = (d == 0) ? cath0 : cath1;
            check($sformatf("%s_seg_s%0d_p%0d", name, s, p), 8'(sg), 8'(e));
            check($sformatf("%s_cath_s%0d_p%0d", name, s, p), 8'(c), 8'(expc));
        end
    endtask

    vec_t vecs[6];

    initial begin
        int t;
        vecs[0] = '{value: 8'd255, h: 7'h6D, t: 7'h5B, o: 7'h5B};
        vecs[1] = '{value: 8'd7,   h: 7'h00, t: 7'h00, o: 7'h70};
        vecs[2] = '{value: 8'd100, h: 7'h30, t: 7'h7E, o: 7'h7E};
        vecs[3] = '{value: 8'd5,   h: 7'h00, t: 7'h00, o: 7'h5B};
        vecs[4] = '{value: 8'd50,  h: 7'h00, t: 7'h5B, o: 7'h7E};
        vecs[5] = '{value: 8'd0,   h: 7'h00, t: 7'h00, o: 7'h7E};

        rst_n = 1'b0;
        vin0 = '0; vv0 = 1'b0;
        vin1 = '0; vv1 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cath", 8'(cath0), 8'hF);
        check("rst_seg", 8'(seg0), 8'h00);
        check("rst_busy", 8'(busy0), 8'd0);
        check("rst_ready", 8'(vr0), 8'd0);

        rst_n = 1'b1;
        #1 check("ready_before_edge", 8'(vr0), 8'd0);
        @(negedge clk);
        check("ready_after_edge", 8'(vr0), 8'd1);
        while (n < 8) begin
            check($sformatf("first_ones_seg_p%0d", n), 8'(seg0), 8'h7E);
            check($sformatf("first_ones_cath_p%0d", n), 8'(cath0), (n < 2) ? 8'hF : 8'hE);
            @(negedge clk);
        end
        scan_check(0, "idle_lz", 7'h00, 7'h00, 7'h7E);
        scan_check(1, "idle_nolz", 7'h7E, 7'h7E, 7'h7E);

        for (int i = 0; i < 6; i++) begin
            send(0, vecs[i].value);
            scan_check(0, $sformatf("v%0d", vecs[i].value), vecs[i].h, vecs[i].t, vecs[i].o);
        end

        send(1, 8'd7);
        scan_check(1, "nolz_7", 7'h7E, 7'h7E, 7'h70);

        // Back-to-back: valid held high across the whole conversion of 12.
        @(negedge clk);
        vin0 = 8'd12; vv0 = 1'b1;
        for (t = 0; t < 50 && !vr0; t++) @(negedge clk);
        @(posedge clk);
        #1 vin0 = 8'd34;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check($sformatf("hold_ready_k%0d", i), 8'(vr0), 8'd0);
        end
        @(negedge clk);
        check("hold_ready_k9", 8'(vr0), 8'd1);
        @(posedge clk);
        #1 vv0 = 1'b0;
        @(negedge clk);
        check("hold_second_accept", 8'(busy0), 8'd1);
        for (t = 0; t < 20 && busy0; t++) @(negedge clk);
        check("hold_busy_end", 8'(busy0), 8'd0);
        scan_check(0, "hold_34", 7'h00, 7'h79, 7'h33);

        // Reset during the fourth shift iteration of a 200 conversion.
        @(negedge clk);
        vin0 = 8'd200; vv0 = 1'b1;
        for (t = 0; t < 50 && !vr0; t++) @(negedge clk);
        @(posedge clk);
        #1 vv0 = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_busy", 8'(busy0), 8'd0);
        check("midrst_cath", 8'(cath0), 8'hF);
        check("midrst_seg", 8'(seg0), 8'h00);
        check("midrst_ready", 8'(vr0), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_ready_back", 8'(vr0), 8'd1);
        scan_check(0, "after_rst", 7'h00, 7'h00, 7'h7E);
        send(0, 8'd200);
        scan_check(0, "v200", 7'h6D, 7'h7E, 7'h7E);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
- Display controller between the CPU's 8-bit output register and the 3-digit multiplexed 7-segment display.
- Accepts a binary value over a valid/ready handshake and converts it to BCD sequentially (double-dabble, one bit per clock).
- Commits the BCD result atomically to a display register, then scans hundreds/tens/ones with a programmable slot period, an anti-ghosting blank window and leading-zero suppression.

Parameters:
- SCAN_DIV, 32768, clk cycles per digit slot; legal range is SCAN_DIV >= 2.
- BLANK_CYC, 64, cycles at the start of each slot with all cathodes off; legal range is 0 <= BLANK_CYC < SCAN_DIV.
- LZ_SUPPRESS, 1, 1 enables leading-zero blanking and 0 always shows all three digits.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- value_in  in  8  binary value to display.
- value_valid  in  1  value_in is valid.
- value_ready  out  1  controller can accept a value this cycle.
- busy  out  1  conversion in progress.
- segments  out  7  {a,b,c,d,e,f,g}, active-high.
- cathode  out  4  active-low digit enables: 1110 ones, 1101 tens, 1011 hundreds; bit 3 is always 1.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, disp register=000, slot=ones, prescaler=0.
  - cathode=1111, segments=0000000, busy=0, value_ready=0.
  - value_ready rises on the first clk edge after release. After that, value_ready=1 exactly when state==IDLE.
- Conversion FSM (IDLE -> SHIFT -> COMMIT -> IDLE):
  - IDLE: value_valid && value_ready at edge k latches value_in into a 20-bit shift register {12'b0, value} and clears the bit counter. State goes to SHIFT.
  - SHIFT: edges k+1..k+8 each perform one iteration: every BCD nibble >= 5 gets +3, then the whole register shifts left by 1. At edge k+8 (counter==7) state goes to COMMIT.
  - COMMIT: edge k+9 copies the BCD field [19:8] to the disp register. State goes to IDLE.
  - Timing: ready is high again after edge k+9, so the earliest next accept is edge k+10. busy=1 in SHIFT and COMMIT.
  - value_valid while busy is ignored and nothing is queued; the sender holds valid until ready.
  - Intermediate values never reach the disp register.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 and wraps. At each wrap, slot advances ones -> tens -> hundreds -> ones.
  - On the edge where prescaler wraps to 0, segments are registered from the disp digit selected by the new slot. Segments stay constant for the whole slot, so a disp update mid-slot appears only at the next slot start (no tearing).
  - For prescaler < BLANK_CYC: cathode=1111.
  - Otherwise: cathode is the slot's code, unless that digit is suppressed, in which case cathode=1111 and segments=0 for the entire slot.
  - The scan runs continuously and is independent of the conversion FSM.
- Leading-zero suppression (LZ_SUPPRESS=1):
  - Hundreds is suppressed iff hundreds==0.
  - Tens is suppressed iff hundreds==0 && tens==0.
  - Ones is never suppressed.
- Decode table (hex, a=bit6):
  - 0=7E, 1=30, 2=6D, 3=79, 4=33
  - 5=5B, 6=5F, 7=70, 8=7F, 9=7B
  - BCD > 9 cannot occur.
- Boundaries:
  - value 0 shows "0".
  - value 255 shows "255".
  - BLANK_CYC=0 means no blank window.
  - Reset mid-conversion aborts the conversion and disp returns to 000.
  - Reset mid-slot forces cathode=1111 immediately.

Test Plan:
- Release reset with SCAN_DIV=8, BLANK_CYC=2 -> value_ready=1 one edge later. Ones slot: cathode 1111 for 2 cycles, then 1110 for 6 cycles with segments=7E. Tens and hundreds slots: cathode 1111 throughout.
- Send 255 at edge k -> busy=1 for edges k+1..k+9, disp=2/5/5 after edge k+9. Scan shows hundreds 6D on 1011, tens 5B on 1101, ones 5B on 1110.
- Send 7 -> hundreds and tens slots stay cathode 1111 / segments 00; ones shows 70. Repeat with LZ_SUPPRESS=0 -> the slots show 7E, 7E, 70.
- Send 100 -> 30, 7E, 7E (the inner zero is not suppressed). Send 5 and then 50 -> 50 displays tens 5B, ones 7E, with hundreds suppressed.
- Hold value_valid=1 with 12 then 34 -> first accept at edge k, value_ready low for k+1..k+9, second accept at edge k+10. Final display shows "34"; "12" appears for at most the slots between the two commits.
- Assert reset during SHIFT iteration 4 of a 200 conversion -> cathode=1111 and busy=0 asynchronously. After release, the display shows "0" and a new 200 conversion completes normally.
